// File: rtl/nexys_starship_monitor.sv
// Play-session monitor for Nexys Starship.
// Watches play_flag from the game FSM, keeps a BCD session timer and a lives
// counter fed by collision hits, and raises game_over once lives run out.
// Timer and lives freeze when a session ends so the end screen can show them.
module nexys_starship_monitor #(
  parameter int TICK_DIV      = 100000000,
  parameter int LIVES         = 3,
  parameter int INVULN_CYCLES = 50000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        play_flag,
  input  logic        hit,
  output logic        game_over,
  output logic [1:0]  lives,
  output logic [15:0] timer_bcd,
  output logic        sec_tick,
  output logic        invuln
);

  localparam int PRE_W = $clog2((TICK_DIV > 1) ? TICK_DIV : 2);
  localparam int INV_W = $clog2((INVULN_CYCLES > 1) ? INVULN_CYCLES : 2);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [INV_W-1:0] INV_LOAD  = INV_W'(INVULN_CYCLES - 1);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [PRE_W-1:0] prescaler;
  logic [INV_W-1:0] inv_cnt;

  logic start;
  logic tick;
  logic hit_ok;

  // Saturating BCD increment: ripple a carry through the four digits, hold at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Session state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the per-cycle strobes that steer the datapath.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    tick       = 1'b0;
    hit_ok     = 1'b0;
    case (state)
      IDLE: begin
        if (play_flag) begin
          next_state = RUN;
          start      = 1'b1;
        end
      end
      RUN: begin
        if (!play_flag) begin
          next_state = IDLE;
        end else begin
          tick   = (prescaler == PRE_LAST);
          hit_ok = hit && !invuln;
          if (hit_ok && (lives <= 2'd1)) begin
            next_state = OVER;
          end
        end
      end
      OVER: begin
        if (!play_flag) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Timer, lives, invulnerability window and game_over bookkeeping.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prescaler <= '0;
      inv_cnt   <= '0;
      timer_bcd <= 16'h0000;
      lives     <= 2'd0;
      game_over <= 1'b0;
      sec_tick  <= 1'b0;
      invuln    <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            prescaler <= '0;
            inv_cnt   <= '0;
            timer_bcd <= 16'h0000;
            lives     <= LIVES_INIT;
            game_over <= 1'b0;
            invuln    <= 1'b0;
          end
        end
        RUN: begin
          if (play_flag) begin
            if (tick) begin
              prescaler <= '0;
              sec_tick  <= 1'b1;
              timer_bcd <= bcd_inc(timer_bcd);
            end else begin
              prescaler <= prescaler + PRE_W'(1);
            end
            if (invuln) begin
              if (inv_cnt == '0) begin
                invuln <= 1'b0;
              end else begin
                inv_cnt <= inv_cnt - INV_W'(1);
              end
            end
            if (hit_ok) begin
              if (lives > 2'd1) begin
                lives <= lives - 2'd1;
                if (INVULN_CYCLES > 0) begin
                  invuln  <= 1'b1;
                  inv_cnt <= INV_LOAD;
                end
              end else begin
                lives     <= 2'd0;
                game_over <= 1'b1;
                invuln    <= 1'b0;
              end
            end
          end
        end
        OVER: begin
          invuln <= 1'b0;
          if (!play_flag) begin
            game_over <= 1'b0;
          end
        end
        default: begin
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nexys_starship_monitor.sv
// Self-checking bench for nexys_starship_monitor.
// A second-counting reference model runs alongside the DUT; every scenario
// task compares the DUT outputs against it each cycle plus directed values.
module tb_nexys_starship_monitor;

  localparam int TICK = 4;
  localparam int NLIV = 3;
  localparam int INV  = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        play_flag = 1'b0;
  logic        hit = 1'b0;
  logic        game_over;
  logic [1:0]  lives;
  logic [15:0] timer_bcd;
  logic        sec_tick;
  logic        invuln;

  int checks = 0;
  int fails  = 0;

  // reference model: session flags plus plain integer counters
  bit m_running;
  bit m_over;
  bit m_tick;
  int m_seconds;
  int m_phase;
  int m_lives;
  int m_inv_left;

  logic [20:0] act;
  logic [20:0] exp_v;

  nexys_starship_monitor #(
    .TICK_DIV(TICK),
    .LIVES(NLIV),
    .INVULN_CYCLES(INV)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .play_flag(play_flag),
    .hit(hit),
    .game_over(game_over),
    .lives(lives),
    .timer_bcd(timer_bcd),
    .sec_tick(sec_tick),
    .invuln(invuln)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] to_bcd(input int s);
    return {4'((s / 1000) % 10), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [20:0] model_vec();
    return {m_over, 2'(m_lives), to_bcd(m_seconds), m_tick, (m_inv_left > 0)};
  endfunction

  task automatic model_reset();
    m_running  = 0;
    m_over     = 0;
    m_tick     = 0;
    m_seconds  = 0;
    m_phase    = 0;
    m_lives    = 0;
    m_inv_left = 0;
  endtask

  // one clock edge of session rules, from the game's point of view
  task automatic model_step(input bit p, input bit h);
    bit accepted;
    m_tick = 0;
    if (m_running) begin
      if (!p) begin
        m_running = 0;
      end else begin
        m_phase++;
        if (m_phase == TICK) begin
          m_phase = 0;
          m_tick  = 1;
          if (m_seconds < 9999) m_seconds++;
        end
        accepted = h && (m_inv_left == 0);
        if (m_inv_left > 0) m_inv_left--;
        if (accepted) begin
          if (m_lives > 1) begin
            m_lives--;
            m_inv_left = INV;
          end else begin
            m_lives    = 0;
            m_over     = 1;
            m_running  = 0;
            m_inv_left = 0;
          end
        end
      end
    end else if (m_over) begin
      m_inv_left = 0;
      if (!p) m_over = 0;
    end else if (p) begin
      m_running  = 1;
      m_seconds  = 0;
      m_phase    = 0;
      m_lives    = NLIV;
      m_inv_left = 0;
    end
  endtask

  // drive inputs on the falling edge, advance the model at the rising edge,
  // and return on the next falling edge ready for sampling
  task automatic applyStimulus(input bit p, input bit h);
    play_flag = p;
    hit       = h;
    @(posedge Clk);
    model_step(p, h);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    model_reset();
    repeat (3) @(negedge Clk);
    checks++;
    if ({game_over, lives, timer_bcd, sec_tick, invuln} !== 21'h0) begin
      fails++;
      $display("[TB] FAIL reset_state: got %h want %h", {game_over, lives, timer_bcd, sec_tick, invuln}, 21'h0);
    end
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1);
      act = {game_over, lives, timer_bcd, sec_tick, invuln};
      exp_v = model_vec();
      checks++;
      if (act !== exp_v) begin
        fails++;
        $display("[TB] FAIL reset_idle cyc %0d: got %h want %h", i, act, exp_v);
      end
    end
  endtask

  task automatic test_timer();
    int pulses = 0;
    int last   = -1;
    for (int i = 0; i <= 40; i++) begin
      applyStimulus(1, 0);
      act = {game_over, lives, timer_bcd, sec_tick, invuln};
      exp_v = model_vec();
      checks++;
      if (act !== exp_v) begin
        fails++;
        $display("[TB] FAIL timer_run cyc %0d: got %h want %h", i, act, exp_v);
      end
      if (sec_tick) begin
        if (last >= 0) begin
          checks++;
          if (i - last !== TICK) begin
            fails++;
            $display("[TB] FAIL tick_spacing: got %0d want %0d", i - last, TICK);
          end
        end
        last = i;
        pulses++;
      end
    end
    checks++;
    if (timer_bcd !== 16'h0010) begin
      fails++;
      $display("[TB] FAIL timer_40: got %h want 0010", timer_bcd);
    end
    checks++;
    if (pulses !== 10) begin
      fails++;
      $display("[TB] FAIL tick_count: got %0d want 10", pulses);
    end
    applyStimulus(0, 0);
  endtask

  task automatic test_hits();
    for (int i = 0; i <= 14; i++) begin
      applyStimulus(1, (i == 5) || (i == 6) || (i == 9) || (i == 13));
      act = {game_over, lives, timer_bcd, sec_tick, invuln};
      exp_v = model_vec();
      checks++;
      if (act !== exp_v) begin
        fails++;
        $display("[TB] FAIL hits cyc %0d: got %h want %h", i, act, exp_v);
      end
      if (i == 6) begin
        checks++;
        if (lives !== 2'd2 || invuln !== 1'b1) begin
          fails++;
          $display("[TB] FAIL hit_ignored: got lives %0d inv %b want 2 1", lives, invuln);
        end
      end
      if (i == 12) begin
        checks++;
        if (game_over !== 1'b0 || lives !== 2'd1) begin
          fails++;
          $display("[TB] FAIL pre_fatal: got go %b lives %0d want 0 1", game_over, lives);
        end
      end
    end
    checks++;
    if (game_over !== 1'b1 || lives !== 2'd0 || timer_bcd !== 16'h0003) begin
      fails++;
      $display("[TB] FAIL game_over: got go %b lives %0d t %h want 1 0 0003", game_over, lives, timer_bcd);
    end
  endtask

  task automatic test_over_hold();
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1, i[0]);
      act = {game_over, lives, timer_bcd, sec_tick, invuln};
      exp_v = model_vec();
      checks++;
      if (act !== exp_v) begin
        fails++;
        $display("[TB] FAIL over_hold cyc %0d: got %h want %h", i, act, exp_v);
      end
    end
    applyStimulus(0, 0);
    checks++;
    if (game_over !== 1'b0 || lives !== 2'd0 || timer_bcd !== 16'h0003) begin
      fails++;
      $display("[TB] FAIL over_release: got go %b lives %0d t %h want 0 0 0003", game_over, lives, timer_bcd);
    end
    applyStimulus(1, 0);
    checks++;
    if (timer_bcd !== 16'h0000 || lives !== 2'd3 || game_over !== 1'b0) begin
      fails++;
      $display("[TB] FAIL restart: got t %h lives %0d go %b want 0000 3 0", timer_bcd, lives, game_over);
    end
  endtask

  task automatic test_bcd();
    int seen_tick = 0;
    applyStimulus(0, 0);
    for (int i = 0; i <= 9999 * TICK + TICK; i++) begin
      applyStimulus(1, 0);
      act = {game_over, lives, timer_bcd, sec_tick, invuln};
      exp_v = model_vec();
      checks++;
      if (act !== exp_v) begin
        fails++;
        $display("[TB] FAIL bcd cyc %0d: got %h want %h", i, act, exp_v);
      end
      if (i == 999 * TICK) begin
        checks++;
        if (timer_bcd !== 16'h0999) begin
          fails++;
          $display("[TB] FAIL bcd_0999: got %h want 0999", timer_bcd);
        end
      end
      if (i == 1000 * TICK) begin
        checks++;
        if (timer_bcd !== 16'h1000 || sec_tick !== 1'b1) begin
          fails++;
          $display("[TB] FAIL bcd_1000: got %h tick %b want 1000 1", timer_bcd, sec_tick);
        end
      end
      if (i > 9999 * TICK && sec_tick) seen_tick++;
    end
    checks++;
    if (timer_bcd !== 16'h9999 || seen_tick !== 1) begin
      fails++;
      $display("[TB] FAIL bcd_saturate: got %h ticks %0d want 9999 1", timer_bcd, seen_tick);
    end
  endtask

  task automatic test_simultaneous();
    applyStimulus(0, 0);
    for (int i = 0; i <= 8; i++) begin
      applyStimulus(1, (i == 1) || (i == 5) || (i == 8));
      act = {game_over, lives, timer_bcd, sec_tick, invuln};
      exp_v = model_vec();
      checks++;
      if (act !== exp_v) begin
        fails++;
        $display("[TB] FAIL fatal_tick cyc %0d: got %h want %h", i, act, exp_v);
      end
    end
    checks++;
    if (game_over !== 1'b1 || timer_bcd !== 16'h0002 || sec_tick !== 1'b1) begin
      fails++;
      $display("[TB] FAIL fatal_on_tick: got go %b t %h tick %b want 1 0002 1", game_over, timer_bcd, sec_tick);
    end
    applyStimulus(0, 0);
    for (int i = 0; i <= 7; i++) begin
      applyStimulus(i < 6, (i == 2) || (i >= 6));
      act = {game_over, lives, timer_bcd, sec_tick, invuln};
      exp_v = model_vec();
      checks++;
      if (act !== exp_v) begin
        fails++;
        $display("[TB] FAIL abort cyc %0d: got %h want %h", i, act, exp_v);
      end
    end
    checks++;
    if (lives !== 2'd2 || game_over !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_hit: got lives %0d go %b want 2 0", lives, game_over);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) < 95, $urandom_range(0, 99) < 12);
      act = {game_over, lives, timer_bcd, sec_tick, invuln};
      exp_v = model_vec();
      checks++;
      if (act !== exp_v) begin
        fails++;
        $display("[TB] FAIL random cyc %0d: got %h want %h", i, act, exp_v);
      end
    end
  endtask

  task automatic test_midreset();
    applyStimulus(0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, i == 3);
    #2 Reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({game_over, lives, timer_bcd, sec_tick, invuln} !== 21'h0) begin
      fails++;
      $display("[TB] FAIL midreset: got %h want %h", {game_over, lives, timer_bcd, sec_tick, invuln}, 21'h0);
    end
    play_flag = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1);
      act = {game_over, lives, timer_bcd, sec_tick, invuln};
      exp_v = model_vec();
      checks++;
      if (act !== exp_v) begin
        fails++;
        $display("[TB] FAIL post_reset cyc %0d: got %h want %h", i, act, exp_v);
      end
    end
    applyStimulus(1, 0);
    checks++;
    if (lives !== 2'd3 || timer_bcd !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL post_reset_start: got lives %0d t %h want 3 0000", lives, timer_bcd);
    end
  endtask

  initial begin
    $display("[TB] starting nexys_starship_monitor bench");
    test_reset();
    test_timer();
    test_hits();
    test_over_hold();
    test_bcd();
    test_simultaneous();
    test_random();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
